// File: rtl/efpga_cfg_pkg.sv
// Shared types and constants for the eFPGA configuration-chain loader.
package efpga_cfg_pkg;

  localparam int unsigned CFG_WORD_W        = 32;
  // Wide enough to hold 0..CFG_WORD_W.
  localparam int unsigned CFG_BITS_W        = 6;
  localparam int unsigned CHAIN_LEN_DEFAULT = 2048;

  typedef enum logic [2:0] {
    StIdle,
    StPreset,
    StWaitWord,
    StShift,
    StDone
  } cfg_state_e;

  // Bits of the next word that still belong to the chain: min(word width, remaining).
  function automatic logic [CFG_BITS_W-1:0] word_bits_of(input logic [31:0] remaining);
    if (remaining >= CFG_WORD_W) return CFG_BITS_W'(CFG_WORD_W);
    return remaining[CFG_BITS_W-1:0];
  endfunction

endpackage

// File: rtl/efpga_ccff_loader_if.sv
// Bitstream word stream (valid/ready) feeding the configuration-chain loader.
interface efpga_ccff_loader_if;
  import efpga_cfg_pkg::*;

  logic                  word_valid;
  logic [CFG_WORD_W-1:0] word_data;
  logic                  word_ready;

  modport master (output word_valid, output word_data, input word_ready);
  modport slave  (input word_valid, input word_data, output word_ready);

endinterface

// File: rtl/efpga_ccff_shifter.sv
// Word shift register, per-word bit counter and chain-tail capture register.
module efpga_ccff_shifter
  import efpga_cfg_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  load,
  input  logic [CFG_WORD_W-1:0] load_word,
  input  logic [CFG_BITS_W-1:0] load_bits,
  input  logic                  shift,
  input  logic                  capture,
  input  logic                  tail_bit,
  output logic                  head_bit,
  output logic                  last_bit,
  output logic [CFG_WORD_W-1:0] tail_word
);

  logic [CFG_WORD_W-1:0] sreg_q;
  logic [CFG_BITS_W-1:0] word_bits_q;
  logic [CFG_WORD_W-1:0] tail_q;

  // Load a new word or drop its LSB once it has been presented to the chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg_q      <= '0;
      word_bits_q <= '0;
    end else if (load) begin
      sreg_q      <= load_word;
      word_bits_q <= load_bits;
    end else if (shift) begin
      sreg_q      <= {1'b0, sreg_q[CFG_WORD_W-1:1]};
      word_bits_q <= word_bits_q - 1'b1;
    end
  end

  // Capture the bit leaving the chain tail on every fabric shift; newest bit in MSB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tail_q <= '0;
    end else if (clear) begin
      tail_q <= '0;
    end else if (capture) begin
      tail_q <= {tail_bit, tail_q[CFG_WORD_W-1:1]};
    end
  end

  assign head_bit  = sreg_q[0];
  assign last_bit  = (word_bits_q == CFG_BITS_W'(1));
  assign tail_word = tail_q;

endmodule

// File: rtl/efpga_ccff_loader.sv
// Configuration-chain programmer: streams bitstream words LSB first into ccff_head
// while holding the fabric in programming reset, and captures ccff_tail for readback.
module efpga_ccff_loader
  import efpga_cfg_pkg::*;
#(
  parameter int unsigned CHAIN_LEN  = CHAIN_LEN_DEFAULT,
  parameter int unsigned CNT_W      = 24,
  parameter int unsigned RST_CYCLES = 4
) (
  input  logic                  CLK0,
  input  logic                  RESET,
  input  logic                  start_i,
  input  logic                  abort_i,
  efpga_ccff_loader_if.slave    word_if,
  output logic                  ccff_head_o,
  input  logic                  ccff_tail_i,
  output logic                  prog_en_o,
  output logic                  preset_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o,
  output logic [CNT_W-1:0]      bits_loaded_o,
  output logic [CFG_WORD_W-1:0] tail_word_o
);

  localparam int unsigned      RcW       = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [CNT_W-1:0] ChainLenC = CNT_W'(CHAIN_LEN);

  cfg_state_e            state_q, state_d;
  logic [RcW-1:0]        rst_cnt_q, rst_cnt_d;
  logic [CNT_W-1:0]      bits_q, remaining;
  logic                  start_acc, word_load, shift_en, last_shift;
  logic                  head_bit, last_bit;
  logic                  ready_q, prog_en_q, head_q, preset_q, busy_q, done_q, error_q;
  logic [CFG_BITS_W-1:0] load_bits;

  assign remaining  = ChainLenC - bits_q;
  assign load_bits  = word_bits_of(32'(remaining));
  assign last_shift = shift_en && (state_d == StDone);

  // Next-state logic and single-cycle strobes; abort overrides every transition.
  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    start_acc = 1'b0;
    word_load = 1'b0;
    shift_en  = 1'b0;
    if (abort_i) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (start_i) begin
            state_d   = StPreset;
            rst_cnt_d = RcW'(RST_CYCLES - 1);
            start_acc = 1'b1;
          end
        end
        StPreset: begin
          if (rst_cnt_q == '0) state_d = StWaitWord;
          else                 rst_cnt_d = rst_cnt_q - 1'b1;
        end
        StWaitWord: begin
          if (word_if.word_valid && ready_q) begin
            word_load = 1'b1;
            state_d   = StShift;
          end
        end
        StShift: begin
          shift_en = 1'b1;
          if (last_bit) state_d = (bits_q + 1'b1 == ChainLenC) ? StDone : StWaitWord;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State and preset countdown registers.
  always_ff @(posedge CLK0 or posedge RESET) begin
    if (RESET) begin
      state_q   <= StIdle;
      rst_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      rst_cnt_q <= rst_cnt_d;
    end
  end

  // Registered outputs; the final shift keeps preset/busy high until the chain has it.
  always_ff @(posedge CLK0 or posedge RESET) begin
    if (RESET) begin
      ready_q   <= 1'b0;
      prog_en_q <= 1'b0;
      head_q    <= 1'b0;
      preset_q  <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      bits_q    <= '0;
    end else begin
      ready_q   <= (state_d == StWaitWord);
      prog_en_q <= shift_en;
      head_q    <= shift_en & head_bit;
      preset_q  <= (state_d != StDone) || last_shift;
      busy_q    <= (state_d inside {StPreset, StWaitWord, StShift}) || last_shift;
      if (start_acc)                                  done_q <= 1'b0;
      else if (state_q == StDone && state_d == StDone) done_q <= 1'b1;
      if (abort_i)        error_q <= 1'b1;
      else if (start_acc) error_q <= 1'b0;
      if (start_acc)     bits_q <= '0;
      else if (shift_en) bits_q <= bits_q + 1'b1;
    end
  end

  efpga_ccff_shifter u_shifter (
    .clk       (CLK0),
    .rst       (RESET),
    .clear     (start_acc),
    .load      (word_load),
    .load_word (word_if.word_data),
    .load_bits (load_bits),
    .shift     (shift_en),
    .capture   (prog_en_q),
    .tail_bit  (ccff_tail_i),
    .head_bit  (head_bit),
    .last_bit  (last_bit),
    .tail_word (tail_word_o)
  );

  assign word_if.word_ready = ready_q;
  assign ccff_head_o        = head_q;
  assign prog_en_o          = prog_en_q;
  assign preset_o           = preset_q;
  assign busy_o             = busy_q;
  assign done_o             = done_q;
  assign error_o            = error_q;
  assign bits_loaded_o      = bits_q;

endmodule
